// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU with RV32M multiply/divide.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Operation codes {m, alt, funct3}
  localparam logic [4:0] OP_ADD    = 5'b0_0_000;
  localparam logic [4:0] OP_SUB    = 5'b0_1_000;
  localparam logic [4:0] OP_SLL    = 5'b0_0_001;
  localparam logic [4:0] OP_SLT    = 5'b0_0_010;
  localparam logic [4:0] OP_SLTU   = 5'b0_0_011;
  localparam logic [4:0] OP_XOR    = 5'b0_0_100;
  localparam logic [4:0] OP_SRL    = 5'b0_0_101;
  localparam logic [4:0] OP_SRA    = 5'b0_1_101;
  localparam logic [4:0] OP_OR     = 5'b0_0_110;
  localparam logic [4:0] OP_AND    = 5'b0_0_111;
  localparam logic [4:0] OP_LUI    = 5'b0_1_111;
  localparam logic [4:0] OP_MUL    = 5'b1_0_000;
  localparam logic [4:0] OP_MULH   = 5'b1_0_001;
  localparam logic [4:0] OP_MULHSU = 5'b1_0_010;
  localparam logic [4:0] OP_MULHU  = 5'b1_0_011;
  localparam logic [4:0] OP_DIV    = 5'b1_0_100;
  localparam logic [4:0] OP_DIVU   = 5'b1_0_101;
  localparam logic [4:0] OP_REM    = 5'b1_0_110;
  localparam logic [4:0] OP_REMU   = 5'b1_0_111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_base.sv
// Single-cycle base integer datapath: add/sub, shifts, compares, logic, LUI pass-through.
module alu_base
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  localparam int SW = $clog2(XLEN);

  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] sra_res;

  assign shamt   = b[SW-1:0];
  // Kept as its own signal so the arithmetic shift stays signed.
  assign sra_res = $signed(a) >>> shamt;

  // Decode funct3, with alt selecting SUB, SRA or LUI where it applies.
  always_comb begin
    y = '0;
    case (op[2:0])
      OP_ADD[2:0]:  y = op[3] ? (a - b) : (a + b);
      OP_SLL[2:0]:  y = a << shamt;
      OP_SLT[2:0]:  y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU[2:0]: y = {{(XLEN-1){1'b0}}, a < b};
      OP_XOR[2:0]:  y = a ^ b;
      OP_SRL[2:0]:  y = op[3] ? sra_res : (a >> shamt);
      OP_OR[2:0]:   y = a | b;
      OP_AND[2:0]:  y = op[3] ? b : (a & b);
      default:      y = '0;
    endcase
  end

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage arithmetic unit: single-cycle base ops plus a bit-serial
// multiply/divide engine.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; in_ready depends on state only, and out/out_valid hold until out_ready.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] in_1,
  input  logic [XLEN-1:0] in_2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output state_e          dbg_state
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state, state_nxt;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] acc_hi, acc_lo, opnd, res_q;
  logic [2:0]      mop;
  logic            neg_q, neg_r;

  // Operand decode in the acceptance cycle
  logic            is_m, is_div, signed_1, signed_2, neg_1, neg_2;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] mag_1, mag_2, special_res, base_res;

  assign is_m     = op[4];
  assign is_div   = op[2];
  assign signed_1 = is_div ? ~op[0] : (op[1:0] != 2'b11);
  assign signed_2 = is_div ? ~op[0] : ~op[1];
  assign neg_1    = signed_1 & in_1[XLEN-1];
  assign neg_2    = signed_2 & in_2[XLEN-1];
  assign mag_1    = neg_1 ? -in_1 : in_1;
  assign mag_2    = neg_2 ? -in_2 : in_2;
  assign div_zero = is_div && (in_2 == '0);
  assign div_ovf  = is_div && ~op[0] && (in_1 == MIN_NEG) && (in_2 == '1);
  assign special  = is_m && (div_zero || div_ovf);
  // op[1] separates REM/REMU from DIV/DIVU.
  assign special_res = div_zero ? (op[1] ? in_1 : '1) : (op[1] ? '0 : in_1);

  alu_base #(.XLEN(XLEN)) u_base (
    .op (op[3:0]),
    .a  (in_1),
    .b  (in_2),
    .y  (base_res)
  );

  // One engine step: shift-add for multiply, restoring subtract for divide
  logic [XLEN:0]     mul_sum, rem_sh, trial;
  logic              fits;
  logic [XLEN-1:0]   step_hi, step_lo, quo, rem, final_res;
  logic [2*XLEN-1:0] prod, prod_s;

  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign rem_sh  = {acc_hi, acc_lo[XLEN-1]};
  assign trial   = rem_sh - {1'b0, opnd};
  assign fits    = ~trial[XLEN];
  assign step_hi = mop[2] ? (fits ? trial[XLEN-1:0] : rem_sh[XLEN-1:0]) : mul_sum[XLEN:1];
  assign step_lo = mop[2] ? {acc_lo[XLEN-2:0], fits} : {mul_sum[0], acc_lo[XLEN-1:1]};

  assign prod      = {step_hi, step_lo};
  assign prod_s    = neg_q ? -prod : prod;
  assign quo       = neg_q ? -step_lo : step_lo;
  assign rem       = neg_r ? -step_hi : step_hi;
  assign final_res = mop[2] ? (mop[1] ? rem : quo)
                            : ((mop[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state and handshake outputs; flush overrides everything
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (!is_m || special) ? S_DONE : S_BUSY;
      end
      S_BUSY: begin
        if (count == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  // Operand capture, iteration and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      res_q  <= '0;
      mop    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (!flush) begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mop <= op[2:0];
            if (!is_m) begin
              res_q <= base_res;
            end else if (special) begin
              res_q <= special_res;
            end else begin
              acc_hi <= '0;
              acc_lo <= is_div ? mag_1 : mag_2;
              opnd   <= is_div ? mag_2 : mag_1;
              neg_q  <= neg_1 ^ neg_2;
              neg_r  <= neg_1;
              count  <= CNT_LAST;
            end
          end
        end
        S_BUSY: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          if (count == '0) res_q <= final_res;
          else             count <= count - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign out       = res_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed and randomized operations
// against an arithmetic reference model.
module tb_alu_muldiv;
  import alu_pkg::*;

  localparam int              XLEN    = 32;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef struct {
    logic [4:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] want;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset, flush, in_valid, out_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] in_1, in_2, out;
  logic            in_ready, out_valid;
  state_e          dbg_state;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  logic [XLEN-1:0] exp_q[$];

  alu_muldiv #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in_1      (in_1),
    .in_2      (in_2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] ref_model(input logic [4:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic signed [2*XLEN+1:0] sa, sb, ua, ub, p;
    logic signed [XLEN-1:0]   as_v, bs_v;
    int sh;
    sh   = int'(b[$clog2(XLEN)-1:0]);
    as_v = a;
    bs_v = b;
    sa   = {{(XLEN+2){a[XLEN-1]}}, a};
    sb   = {{(XLEN+2){b[XLEN-1]}}, b};
    ua   = {{(XLEN+2){1'b0}}, a};
    ub   = {{(XLEN+2){1'b0}}, b};
    if (!o[4]) begin
      case (o[2:0])
        3'd0: return o[3] ? a - b : a + b;
        3'd1: return a << sh;
        3'd2: return {{(XLEN-1){1'b0}}, as_v < bs_v};
        3'd3: return {{(XLEN-1){1'b0}}, a < b};
        3'd4: return a ^ b;
        3'd5: return o[3] ? as_v >>> sh : a >> sh;
        3'd6: return a | b;
        default: return o[3] ? b : a & b;
      endcase
    end
    case (o[2:0])
      3'd0: begin p = sa * sb; return p[XLEN-1:0]; end
      3'd1: begin p = sa * sb; return p[2*XLEN-1:XLEN]; end
      3'd2: begin p = sa * ub; return p[2*XLEN-1:XLEN]; end
      3'd3: begin p = ua * ub; return p[2*XLEN-1:XLEN]; end
      3'd4: begin
        if (b == '0) return '1;
        if (a == MIN_NEG && b == '1) return a;
        return as_v / bs_v;
      end
      3'd5: return (b == '0) ? '1 : a / b;
      3'd6: begin
        if (b == '0) return a;
        if (a == MIN_NEG && b == '1) return '0;
        return as_v % bs_v;
      end
      default: return (b == '0) ? a : a % b;
    endcase
  endfunction

  // Cycles from acceptance to the first cycle with out_valid.
  function automatic int exp_lat(input logic [4:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    if (!o[4]) return 1;
    if (o[2] && (b == '0 || (!o[0] && a == MIN_NEG && b == '1))) return 1;
    return XLEN + 1;
  endfunction

  function automatic logic [XLEN-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return XLEN'(1);
      2: return '1;
      3: return MIN_NEG;
      4: return XLEN'($urandom_range(0, 20));
      default: return XLEN'($urandom);
    endcase
  endfunction

  // ---------------- driver ----------------
  // Presents one op with out_ready high, scrambles inputs after acceptance and
  // returns the result, its latency and the acceptance cycle number.
  task automatic issue(input logic [4:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       output logic [XLEN-1:0] res, output int lat, output int acc_cycle);
    @(negedge clk);
    op = o; in_1 = a; in_2 = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    acc_cycle = cycle;
    in_valid = 1'b0; op = 5'($urandom); in_1 = XLEN'($urandom); in_2 = XLEN'($urandom);
    lat = 0;
    res = 'x;
    while (lat <= XLEN + 10) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin
        res = out;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; in_1 = '0; in_2 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out !== '0) begin failures++; $display("FAIL reset_out got=%h want=0", out); end
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, S_IDLE); end
  endtask

  task automatic run_vectors(input string name, input vec_t v[$]);
    logic [XLEN-1:0] res;
    int lat, acc;
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b, res, lat, acc);
      checks++;
      if (res !== v[i].want) begin
        failures++;
        $display("FAIL %s op=%b a=%h b=%h got=%h want=%h", name, v[i].op, v[i].a, v[i].b, res, v[i].want);
      end
      checks++;
      if (lat != exp_lat(v[i].op, v[i].a, v[i].b)) begin
        failures++;
        $display("FAIL %s_latency op=%b got=%0d want=%0d", name, v[i].op, lat, exp_lat(v[i].op, v[i].a, v[i].b));
      end
    end
  endtask

  task automatic test_base();
    vec_t v[$];
    v.push_back('{OP_ADD,  32'd5,         32'd7,         32'd12});
    v.push_back('{OP_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000});
    v.push_back('{OP_LUI,  32'h0000_DEAD, 32'h1234_5000, 32'h1234_5000});
    v.push_back('{OP_SUB,  32'd5,         32'd7,         32'hFFFF_FFFE});
    v.push_back('{OP_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1});
    v.push_back('{OP_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0});
    v.push_back('{OP_SRL,  32'h8000_0000, 32'd36,        32'h0800_0000});
    v.push_back('{OP_SLL,  32'h0000_0003, 32'd31,        32'h8000_0000});
    run_vectors("base_directed", v);
  endtask

  task automatic test_mul();
    vec_t v[$];
    v.push_back('{OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001});
    v.push_back('{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000});
    v.push_back('{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    v.push_back('{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    v.push_back('{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
    run_vectors("mul_directed", v);
  endtask

  task automatic test_div();
    vec_t v[$];
    v.push_back('{OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD});
    v.push_back('{OP_REM,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001});
    v.push_back('{OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF});
    v.push_back('{OP_DIVU, 32'd100,       32'd7,         32'd14});
    v.push_back('{OP_DIVU, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF});
    v.push_back('{OP_REMU, 32'h0000_1234, 32'd0,         32'h0000_1234});
    v.push_back('{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    v.push_back('{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
    v.push_back('{OP_DIV,  32'h0000_1234, 32'd0,         32'hFFFF_FFFF});
    v.push_back('{OP_REM,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9});
    run_vectors("div_directed", v);
  endtask

  task automatic test_random();
    logic [4:0]      o;
    logic [XLEN-1:0] a, b, res, want;
    int lat, acc;
    for (int i = 0; i < 90; i++) begin
      if (i < 30) o = {1'b0, 4'($urandom_range(0, 15))};
      else        o = {2'b10, 3'($urandom_range(0, 7))};
      a = pick();
      b = pick();
      want = ref_model(o, a, b);
      issue(o, a, b, res, lat, acc);
      checks++;
      if (res !== want) begin
        failures++;
        $display("FAIL random op=%b a=%h b=%h got=%h want=%h", o, a, b, res, want);
      end
      checks++;
      if (lat != exp_lat(o, a, b)) begin
        failures++;
        $display("FAIL random_latency op=%b got=%0d want=%0d", o, lat, exp_lat(o, a, b));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]      ops[6];
    logic [XLEN-1:0] a, b, res, want;
    int lat, acc, prev_acc, gap;
    ops = '{OP_ADD, OP_XOR, OP_MUL, OP_OR, OP_DIVU, OP_SLT};
    prev_acc = -1;
    for (int i = 0; i < 6; i++) begin
      a = XLEN'($urandom);
      b = XLEN'($urandom_range(1, 1000));
      exp_q.push_back(ref_model(ops[i], a, b));
      issue(ops[i], a, b, res, lat, acc);
      want = exp_q.pop_front();
      checks++;
      if (res !== want) begin
        failures++;
        $display("FAIL b2b_result op=%b got=%h want=%h", ops[i], res, want);
      end
      if (i > 0) begin
        gap = (ops[i-1][4]) ? XLEN + 2 : 2;
        checks++;
        if (acc - prev_acc != gap) begin
          failures++;
          $display("FAIL b2b_throughput op=%b got=%0d want=%0d", ops[i-1], acc - prev_acc, gap);
        end
      end
      prev_acc = acc;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad_ready;
    @(negedge clk);
    op = OP_MUL; in_1 = 32'd3; in_2 = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; in_1 = XLEN'($urandom); in_2 = XLEN'($urandom);
    lat = 0;
    bad_ready = 0;
    while (lat <= XLEN + 10) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (in_ready !== 1'b0) bad_ready++;
    end
    checks++; if (lat != XLEN + 1) begin failures++; $display("FAIL bp_latency got=%0d want=%0d", lat, XLEN + 1); end
    checks++; if (bad_ready != 0) begin failures++; $display("FAIL bp_busy_in_ready got=%0d want=0 cycles high", bad_ready); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_1 = XLEN'($urandom);
      checks++; if (out !== 32'd12) begin failures++; $display("FAIL bp_out_stable cyc=%0d got=%h want=%h", i, out, 32'd12); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid cyc=%0d got=%b want=1", i, out_valid); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", i, in_ready); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_out_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b want=1", in_ready); end
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL bp_release_state got=%0d want=%0d", dbg_state, S_IDLE); end
  endtask

  // Starts a DIV and aborts it during cycle 10 with either flush or reset.
  task automatic test_abort(input bit use_reset);
    string name;
    int early;
    name = use_reset ? "reset_busy" : "flush";
    @(negedge clk);
    op = OP_DIV; in_1 = 32'd1000; in_2 = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    early = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) early++;
      if (k == 10) begin
        if (use_reset) reset = 1'b1;
        else           flush = 1'b1;
      end
    end
    @(posedge clk); #1;
    reset = 1'b0; flush = 1'b0;
    op = OP_ADD; in_1 = 32'd5; in_2 = 32'd7; in_valid = 1'b1;
    @(negedge clk);
    checks++; if (early != 0) begin failures++; $display("FAIL %s_early_valid got=%0d want=0", name, early); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL %s_in_ready got=%b want=1", name, in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL %s_out_valid got=%b want=0", name, out_valid); end
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL %s_state got=%0d want=%0d", name, dbg_state, S_IDLE); end
    if (use_reset) begin
      checks++; if (out !== '0) begin failures++; $display("FAIL %s_out got=%h want=0", name, out); end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL %s_next_valid got=%b want=1", name, out_valid); end
    checks++; if (out !== 32'd12) begin failures++; $display("FAIL %s_next_result got=%h want=%h", name, out, 32'd12); end
  endtask

  task automatic test_flush_vs_accept();
    @(negedge clk);
    op = OP_ADD; in_1 = 32'd1; in_2 = 32'd2; in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_accept_out_valid got=%b want=0", out_valid); end
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL flush_accept_state got=%0d want=%0d", dbg_state, S_IDLE); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_base();
    test_mul();
    test_div();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_abort(1'b0);
    test_abort(1'b1);
    test_flush_vs_accept();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
